// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM states,
// stall-length constants and a small max helper.
package mips_hazard_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    localparam logic [1:0] STALL_NONE    = 2'd0;
    localparam logic [1:0] STALL_ONE     = 2'd1;
    localparam logic [1:0] STALL_LOAD_BR = 2'd2;

    // Larger of two stall requests; overlapping hazards take the longest wait.
    function automatic logic [1:0] stall_max(input logic [1:0] a, input logic [1:0] b);
        stall_max = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Single source-vs-destination comparator. Register 0 is hardwired to zero,
// so a destination of 0 never produces a hit.
module hazard_match (
    input  logic [4:0] i_src,
    input  logic [4:0] i_dst,
    input  logic       i_we,
    output logic       o_hit
);

    assign o_hit = i_we & (i_dst != 5'd0) & (i_src == i_dst);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller for a 5-stage MIPS pipeline with branches
// resolved in ID: computes stall length, MEM->ID forwarding for the branch
// compare, taken-branch flush and optional saturating performance counters.
// Optional feature macro: HAZARD_PERF_CNT_EN (counters present when defined;
// otherwise stall_cnt/flush_cnt are tied to 0 and no counter flops exist).
module id_hazard_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_branch,
    input  logic             id_uses_rt,
    input  logic             zero,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_reg,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_write_reg,
    output logic             fw_rs,
    output logic             fw_rt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             pc_src,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e  r_state;
    hz_state_e  w_state_nxt;
    logic [1:0] r_rem;
    logic [1:0] w_rem_nxt;
    logic [1:0] w_need;
    logic       w_stall_fsm;
    logic       w_stall;
    logic       w_flush;

    logic w_ex_rs_hit, w_ex_rt_hit, w_mem_rs_hit, w_mem_rt_hit;
    logic w_ex_we, w_mem_we;

    // A load writes its destination even if reg_write is not flagged with it.
    assign w_ex_we  = ex_reg_write | ex_mem_read;
    assign w_mem_we = mem_reg_write | mem_mem_read;

    hazard_match u_ex_rs  (.i_src(id_rs), .i_dst(ex_write_reg),  .i_we(w_ex_we),  .o_hit(w_ex_rs_hit));
    hazard_match u_ex_rt  (.i_src(id_rt), .i_dst(ex_write_reg),  .i_we(w_ex_we),  .o_hit(w_ex_rt_hit));
    hazard_match u_mem_rs (.i_src(id_rs), .i_dst(mem_write_reg), .i_we(w_mem_we), .o_hit(w_mem_rs_hit));
    hazard_match u_mem_rt (.i_src(id_rt), .i_dst(mem_write_reg), .i_we(w_mem_we), .o_hit(w_mem_rt_hit));

    // Required stall length for the instruction currently in ID (max over all cases).
    always_comb begin
        w_need = STALL_NONE;
        if (id_branch) begin
            if ((w_ex_rs_hit | w_ex_rt_hit) & ex_mem_read) begin
                w_need = stall_max(w_need, STALL_LOAD_BR);
            end else if (w_ex_rs_hit | w_ex_rt_hit) begin
                w_need = stall_max(w_need, STALL_ONE);
            end else begin
                w_need = w_need;
            end
            if ((w_mem_rs_hit | w_mem_rt_hit) & mem_mem_read) begin
                w_need = stall_max(w_need, STALL_ONE);
            end else begin
                w_need = w_need;
            end
        end else begin
            if (ex_mem_read & (w_ex_rs_hit | (w_ex_rt_hit & id_uses_rt))) begin
                w_need = STALL_ONE;
            end else begin
                w_need = STALL_NONE;
            end
        end
    end

    // Stall FSM next-state: RUN stalls on demand, STALL counts down the remainder.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stall_fsm = 1'b0;
        case (r_state)
            RUN: begin
                if (w_need != STALL_NONE) begin
                    w_stall_fsm = 1'b1;
                    if (w_need == STALL_LOAD_BR) begin
                        w_state_nxt = STALL;
                        w_rem_nxt   = STALL_ONE;
                    end else begin
                        w_state_nxt = RUN;
                        w_rem_nxt   = 2'd0;
                    end
                end else begin
                    w_state_nxt = RUN;
                    w_rem_nxt   = 2'd0;
                end
            end
            STALL: begin
                w_stall_fsm = 1'b1;
                if (r_rem <= 2'd1) begin
                    w_state_nxt = RUN;
                    w_rem_nxt   = 2'd0;
                end else begin
                    w_state_nxt = STALL;
                    w_rem_nxt   = r_rem - 2'd1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_rem_nxt   = 2'd0;
            end
        endcase
    end

    // FSM state and remaining-cycle register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_rem   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Reset releases the pipeline at once, even if hazard inputs are still present.
    assign w_stall = w_stall_fsm & ~rst;
    assign w_flush = id_branch & zero & ~w_stall;

    assign pc_write     = ~w_stall;
    assign if_id_write  = ~w_stall;
    assign id_ex_bubble = w_stall;
    assign pc_src       = w_flush;
    assign if_id_flush  = w_flush;

    // Forward ALU results sitting in MEM only for the branch compare.
    assign fw_rs = ~w_stall & id_branch & mem_reg_write & ~mem_mem_read & w_mem_rs_hit;
    assign fw_rt = ~w_stall & id_branch & mem_reg_write & ~mem_mem_read & w_mem_rt_hit;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating stall/flush event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: a reference model counts outstanding
// stall cycles directly from the hazard rules, pushes the expected outputs per
// cycle, and a negedge monitor pops and compares.
module tb_id_hazard_ctrl;

    localparam int TB_CNT_W = 8;
    localparam int CMAX     = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0;
    logic id_branch = 1'b0, id_uses_rt = 1'b0, zero = 1'b0;
    logic ex_reg_write = 1'b0, ex_mem_read = 1'b0;
    logic [4:0] ex_write_reg = 5'd0;
    logic mem_reg_write = 1'b0, mem_mem_read = 1'b0;
    logic [4:0] mem_write_reg = 5'd0;
    logic fw_rs, fw_rt, pc_write, if_id_write, id_ex_bubble, pc_src, if_id_flush;
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

    id_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_branch(id_branch), .id_uses_rt(id_uses_rt), .zero(zero),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
        .fw_rs(fw_rs), .fw_rt(fw_rt), .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .pc_src(pc_src), .if_id_flush(if_id_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pc_write, if_id_write, bubble, fw_rs, fw_rt, pc_src, flush;
        int   scnt, fcnt;
        int   tag;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc = 0;

    // Reference model state: cycles of stall still owed, plus event totals.
    int m_left = 0;
    int m_scnt = 0;
    int m_fcnt = 0;

    task automatic chk(input string name, input int tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, tag, act, exp);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; compare against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_write",     e.tag, int'(pc_write),     int'(e.pc_write));
            chk("if_id_write",  e.tag, int'(if_id_write),  int'(e.if_id_write));
            chk("id_ex_bubble", e.tag, int'(id_ex_bubble), int'(e.bubble));
            chk("fw_rs",        e.tag, int'(fw_rs),        int'(e.fw_rs));
            chk("fw_rt",        e.tag, int'(fw_rt),        int'(e.fw_rt));
            chk("pc_src",       e.tag, int'(pc_src),       int'(e.pc_src));
            chk("if_id_flush",  e.tag, int'(if_id_flush),  int'(e.flush));
            chk("stall_cnt",    e.tag, int'(stall_cnt),    e.scnt);
            chk("flush_cnt",    e.tag, int'(flush_cnt),    e.fcnt);
        end
    end

    function automatic bit writes(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // Stall cycles owed by the ID instruction, straight from the hazard table.
    function automatic int need_cycles();
        int n = 0;
        bit ex_hit  = writes(ex_write_reg, id_rs)  || writes(ex_write_reg, id_rt);
        bit mem_hit = writes(mem_write_reg, id_rs) || writes(mem_write_reg, id_rt);
        if (id_branch) begin
            if (ex_mem_read && ex_hit) n = (n > 2) ? n : 2;
            if (ex_reg_write && !ex_mem_read && ex_hit) n = (n > 1) ? n : 1;
            if (mem_mem_read && mem_hit) n = (n > 1) ? n : 1;
        end else if (ex_mem_read &&
                     (writes(ex_write_reg, id_rs) || (id_uses_rt && writes(ex_write_reg, id_rt)))) begin
            n = 1;
        end
        return n;
    endfunction

    // Apply one cycle of inputs (at posedge+1), record expectation, advance model.
    task automatic cyc(input logic r, input logic br, input logic urt, input logic z,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic exw, input logic exr, input logic [4:0] exd,
                       input logic mw, input logic mr, input logic [4:0] md);
        exp_t e;
        int n = 0;
        bit stalled, fl;
        rst = r; id_branch = br; id_uses_rt = urt; zero = z; id_rs = rs; id_rt = rt;
        ex_reg_write = exw; ex_mem_read = exr; ex_write_reg = exd;
        mem_reg_write = mw; mem_mem_read = mr; mem_write_reg = md;
        if (r) begin
            stalled = 1'b0;
        end else if (m_left > 0) begin
            stalled = 1'b1;
        end else begin
            n = need_cycles();
            stalled = (n > 0);
        end
        fl = br && z && !stalled;
        e.pc_write    = !stalled;
        e.if_id_write = !stalled;
        e.bubble      = stalled;
        e.fw_rs  = !stalled && br && mw && !mr && writes(md, rs);
        e.fw_rt  = !stalled && br && mw && !mr && writes(md, rt);
        e.pc_src = fl;
        e.flush  = fl;
`ifdef HAZARD_PERF_CNT_EN
        e.scnt = r ? 0 : m_scnt;
        e.fcnt = r ? 0 : m_fcnt;
`else
        e.scnt = 0;
        e.fcnt = 0;
`endif
        e.tag = n_cyc;
        exp_q.push_back(e);
        if (r) begin
            m_left = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (m_left > 0) m_left--;
            else if (n > 0) m_left = n - 1;
            if (stalled && m_scnt < CMAX) m_scnt++;
            if (fl && m_fcnt < CMAX) m_fcnt++;
        end
        n_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        cyc(r, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        // lw $5 in EX, beq $5,$6 in ID: two stall cycles, then release.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        idle(1'b0);
        // add $7 in MEM, beq $7,$7 taken: forward both operands and flush.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd7);
        idle(1'b0);
        // lw $3 in EX, add reads rt=$3: one stall; without rt use, none.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0);
        // Destination $0 never hazards or forwards.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0);
        // Reset asserted in the STALL cycle abandons it immediately.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
        idle(1'b0);
        // Randomized traffic over a small register window to provoke matches.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
        end
        // Counter saturation: continuous load-use stall for 2^CNT_W+3 cycles.
        idle(1'b1);
        for (int i = 0; i < (1 << TB_CNT_W) + 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0);
        end
        idle(1'b0);
        // Every issued expectation must have been consumed by the monitor.
        chk("queue_drain", n_cyc, exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of each performance counter.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-004 The block SHALL have ports id_rs and id_rt, input, 5 each, the source register fields of the instruction in ID.
REQ-005 The block SHALL have port id_branch, input, 1, meaning a beq is in ID; id_uses_rt, input, 1, meaning the ID instruction reads rt.
REQ-006 The block SHALL have port zero, input, 1, the ID-stage equality compare result.
REQ-007 The block SHALL have ports ex_reg_write, ex_mem_read, input, 1 each, and ex_write_reg, input, 5: the EX-stage destination information.
REQ-008 The block SHALL have ports mem_reg_write, mem_mem_read, input, 1 each, and mem_write_reg, input, 5: the MEM-stage destination information.
REQ-009 The block SHALL have ports fw_rs and fw_rt, output, 1 each, selecting alu_result_mem for the ID compare operands.
REQ-010 The block SHALL have ports pc_write, if_id_write, output, 1 each (0 = hold); id_ex_bubble, output, 1 (1 = zero ID/EX controls).
REQ-011 The block SHALL have ports pc_src, if_id_flush, output, 1 each, for a taken branch.
REQ-012 The block SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, the performance counters.

Function
REQ-013 A match SHALL require a nonzero destination register; register 0 never causes a hazard or forward.
REQ-014 The required stall count N SHALL be: 2 for a branch whose rs/rt matches an EX load; 1 for a branch matching an EX non-load write; 1 for a branch matching a MEM load; 1 for a non-branch matching an EX load on rs, or on rt when id_uses_rt=1; otherwise 0. When several cases apply, N SHALL be the maximum.
REQ-015 The FSM SHALL have states RUN and STALL, with a 2-bit remaining-cycle counter rem.
REQ-016 In RUN with N>0, the stall SHALL be asserted in the same cycle; if N=2, the next state SHALL be STALL with rem=1; if N=1, the state SHALL stay RUN.
REQ-017 In STALL, the stall SHALL be asserted unconditionally, detection SHALL be ignored, rem SHALL decrement, and the FSM SHALL return to RUN when rem reaches 0.
REQ-018 While the stall is asserted, the outputs SHALL be pc_write=0, if_id_write=0, id_ex_bubble=1; otherwise 1, 1, 0.
REQ-019 When not stalled, fw_rs SHALL be 1 iff id_branch, mem_reg_write, !mem_mem_read, and mem_write_reg==id_rs; fw_rt SHALL use the same rule with id_rt. Both SHALL be 0 during a stall.
REQ-020 pc_src and if_id_flush SHALL equal id_branch & zero & !stall, combinationally; a stall SHALL suppress a flush in the same cycle.
REQ-021 stall_cnt SHALL increment each stalled cycle, flush_cnt each flush cycle; both SHALL saturate at all-ones.

Reset
REQ-022 Assertion of rst SHALL immediately force state RUN, rem=0, and both counters to 0. This gives pc_write=1, if_id_write=1, id_ex_bubble=0, fw_rs=fw_rt=0, pc_src=if_id_flush=0 when id_branch=0.
REQ-023 Reset mid-STALL SHALL abandon the remaining stall cycle.

Configuration
REQ-024 With HAZARD_PERF_CNT_EN defined, the counters SHALL operate per REQ-021. Without it, stall_cnt and flush_cnt SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-025 Package mips_hazard_pkg SHALL hold the state enum (RUN, STALL) and the constants STALL_LOAD_BR=2 and STALL_ONE=1.
REQ-026 One sub-module, hazard_match, SHALL compare a 5-bit source against a destination with a write enable and a nonzero check; it SHALL be instantiated per source/stage pair.

Verification
REQ-027 lw $5 in EX (ex_mem_read=1, ex_write_reg=5) with beq $5,$6 in ID -> two stall cycles: pc_write=0 in cycles t and t+1, then 1; stall_cnt=2.
REQ-028 add $7 in MEM (mem_reg_write=1, mem_write_reg=7) with beq $7,$7 in ID -> fw_rs=fw_rt=1 and no stall; zero=1 -> pc_src=1, if_id_flush=1, flush_cnt=1.
REQ-029 lw $3 in EX with add using rt=$3, id_uses_rt=1 -> one stall cycle and id_ex_bubble=1; with id_uses_rt=0 -> no stall.
REQ-030 ex_write_reg=0 with ex_mem_read=1 and id_rs=0 -> no stall and no forward.
REQ-031 Assert rst in the STALL cycle of REQ-027 -> pc_write=1 immediately and counters 0; drive 2^CNT_W+3 stall cycles -> stall_cnt holds all-ones.
